// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder slice.
// Contents:
//   state_t  - FSM state encoding (IDLE / RUN / DONE), 2 bits wide
//   STATE_W  - width of the FSM state register
package bit_serial_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Start/done handshake bundle between the issuing logic and the bit-serial adder.
// Signals:
//   start  - request, accepted only while the adder is idle or done
//   a, b   - operands (WIDTH bits), cin - carry-in; captured on an accepted start
//   busy   - high while an addition is in progress
//   done   - one-cycle pulse when a new result is available
//   sum    - registered result (WIDTH bits), cout - registered final carry
// Modports: master = issuing logic, slave = adder.
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/bit_serial_adder_fa_bit.sv
// Purely combinational one-bit full adder; the single arithmetic cell the
// serial adder reuses every cycle.
// Ports:
//   a_i, b_i, cin_i - operand bits and carry-in
//   s_o             - sum bit
//   cout_o          - carry-out
module fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    logic halfSum;

    assign halfSum = a_i ^ b_i;
    assign s_o     = halfSum ^ cin_i;
    assign cout_o  = (a_i & b_i) | (cin_i & halfSum);

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-bit adder that streams operands LSB first through one full-adder
// cell, producing one sum bit per clock. A carry flip-flop chains the bits.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of bit_serial_adder_if (start/a/b/cin in,
//          busy/done/sum/cout out)
// A result takes WIDTH cycles of RUN; done pulses in the following cycle.
module bit_serial_adder
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    bit_serial_adder_if.slave  bus
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sa_q, sb_q, acc_q, sum_q;
    logic             carry_q, cout_q;
    logic [WIDTH-1:0] accNext;
    logic             faSum, faCout;
    logic             accept, lastBit;

    // A new request is only taken when no addition is in flight.
    assign accept  = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign lastBit = (state_q == RUN) && (cnt_q == LAST_CNT);

    fa_bit uFa (
        .a_i    (sa_q[0]),
        .b_i    (sb_q[0]),
        .cin_i  (carry_q),
        .s_o    (faSum),
        .cout_o (faCout)
    );

    // New sum bits enter at the MSB so that after WIDTH shifts the LSB
    // computed first has reached bit 0. A one-bit adder has nothing to shift.
    generate
        if (WIDTH == 1) begin : gNarrow
            assign accNext = faSum;
        end else begin : gWide
            assign accNext = {faSum, acc_q[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state.
    always_comb begin
        bus.busy = (state_q == RUN);
        bus.done = (state_q == DONE);
    end

    // Datapath: operand capture, serial shifting, and the result registers,
    // which are written only on the final bit so partial sums never leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            acc_q   <= '0;
            carry_q <= bus.cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            acc_q   <= accNext;
            sa_q    <= sa_q >> 1;
            sb_q    <= sb_q >> 1;
            carry_q <= faCout;
            cnt_q   <= cnt_q + 1'b1;
            if (lastBit) begin
                sum_q  <= accNext;
                cout_q <= faCout;
            end
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH = 8, 1 and 13.
// Expected {cout,sum} values are computed from a + b + cin when a request is
// issued, queued, and compared when the matching done pulse appears.
module tb_bit_serial_adder;

    logic clk;
    logic rst8, rst1, rst13;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [32:0] q8[$];
    logic [32:0] q1[$];
    logic [32:0] q13[$];

    logic [7:0] lastSum8;
    logic       lastCout8;

    bit_serial_adder_if #(.WIDTH(8))  if8 ();
    bit_serial_adder_if #(.WIDTH(1))  if1 ();
    bit_serial_adder_if #(.WIDTH(13)) if13 ();

    bit_serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(if8));
    bit_serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst1),  .bus(if1));
    bit_serial_adder #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst13), .bus(if13));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one accepted start on the 8-bit adder and queue its expected result.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        if8.cin   = c;
        q8.push_back(33'(9'(a) + 9'(b) + 9'(c)));
        step();
        if8.start = 1'b0;
        if8.a     = 8'($urandom);
        if8.b     = 8'($urandom);
        if8.cin   = 1'($urandom);
    endtask

    // Follow an 8-bit operation cycle by cycle up to its done cycle.
    // injectAt >= 0 pulses a conflicting start during that RUN cycle index.
    task automatic runOp8(input string tag, input int injectAt);
        logic [32:0] exp;
        for (int i = 0; i < 8; i++) begin
            checkOutput({tag, ".busy"}, if8.busy, 1);
            checkOutput({tag, ".doneEarly"}, if8.done, 0);
            checkOutput({tag, ".sumHold"}, if8.sum, lastSum8);
            checkOutput({tag, ".coutHold"}, if8.cout, lastCout8);
            if (i == injectAt) begin
                if8.start = 1'b1;
                if8.a     = 8'hFF;
                if8.b     = 8'hFF;
                if8.cin   = 1'b1;
            end
            step();
            if8.start = 1'b0;
        end
        checkOutput({tag, ".busyEnd"}, if8.busy, 0);
        checkOutput({tag, ".done"}, if8.done, 1);
        checkOutput({tag, ".sbNotEmpty"}, q8.size() > 0, 1);
        if (q8.size() > 0) begin
            exp = q8.pop_front();
            checkOutput({tag, ".sum"}, if8.sum, exp[7:0]);
            checkOutput({tag, ".cout"}, if8.cout, exp[8]);
            lastSum8  = exp[7:0];
            lastCout8 = exp[8];
        end
    endtask

    initial begin
        logic [32:0] e;
        logic [12:0] ra, rb;
        logic        rc;
        logic [2:0]  combo;
        int          n;

        if8.start = 0;  if8.a = 0;  if8.b = 0;  if8.cin = 0;
        if1.start = 0;  if1.a = 0;  if1.b = 0;  if1.cin = 0;
        if13.start = 0; if13.a = 0; if13.b = 0; if13.cin = 0;
        rst8 = 1; rst1 = 1; rst13 = 1;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.busy", if8.busy, 0);
        checkOutput("reset.done", if8.done, 0);
        checkOutput("reset.sum", if8.sum, 0);
        checkOutput("reset.cout", if8.cout, 0);
        checkOutput("reset13.sum", if13.sum, 0);
        rst8 = 0; rst1 = 0; rst13 = 0;
        lastSum8 = 8'h00;
        lastCout8 = 1'b0;
        step();

        // Carry ripples through every bit.
        applyStimulus(8'hFF, 8'h01, 1'b0);
        runOp8("ffPlus1", -1);
        step();
        checkOutput("ffPlus1.doneOnce", if8.done, 0);
        checkOutput("ffPlus1.idleBusy", if8.busy, 0);

        // Mixed pattern with carry-in, then a back-to-back request in DONE.
        applyStimulus(8'h5A, 8'h3C, 1'b1);
        runOp8("mixed", -1);
        applyStimulus(8'h80, 8'h80, 1'b0);
        runOp8("backToBack", -1);
        step();
        checkOutput("backToBack.idle", if8.done, 0);

        // A start during RUN must be ignored.
        applyStimulus(8'h01, 8'h01, 1'b0);
        runOp8("ignoreStart", 2);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("ignoreStart.noExtraDone", if8.done, 0);
            checkOutput("ignoreStart.noExtraBusy", if8.busy, 0);
        end

        // Reset in RUN cycle 4 abandons the operation and clears the result.
        applyStimulus(8'h77, 8'h11, 1'b0);
        repeat (3) step();
        rst8 = 1;
        step();
        rst8 = 0;
        checkOutput("midReset.busy", if8.busy, 0);
        checkOutput("midReset.done", if8.done, 0);
        checkOutput("midReset.sum", if8.sum, 0);
        checkOutput("midReset.cout", if8.cout, 0);
        void'(q8.pop_back());
        lastSum8  = 8'h00;
        lastCout8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("midReset.noDone", if8.done, 0);
        end
        applyStimulus(8'h10, 8'h20, 1'b0);
        runOp8("afterReset", -1);
        step();

        // Random back-to-back operations at WIDTH=8.
        for (int k = 0; k < 1000; k++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom));
            runOp8("rand8", -1);
        end
        step();

        // WIDTH=1: full-adder truth table.
        for (int k = 0; k < 8; k++) begin
            combo = 3'(k);
            if1.start = 1'b1;
            if1.a     = combo[2];
            if1.b     = combo[1];
            if1.cin   = combo[0];
            q1.push_back(33'(2'(combo[2]) + 2'(combo[1]) + 2'(combo[0])));
            step();
            if1.start = 1'b0;
            checkOutput("w1.busy", if1.busy, 1);
            checkOutput("w1.doneEarly", if1.done, 0);
            step();
            checkOutput("w1.done", if1.done, 1);
            e = q1.pop_front();
            checkOutput("w1.sum", if1.sum, e[0]);
            checkOutput("w1.cout", if1.cout, e[1]);
            step();
        end

        // Random operations at WIDTH=13 with a bounded wait for done.
        for (int k = 0; k < 1000; k++) begin
            ra = 13'($urandom);
            rb = 13'($urandom);
            rc = 1'($urandom);
            if13.start = 1'b1;
            if13.a     = ra;
            if13.b     = rb;
            if13.cin   = rc;
            q13.push_back(33'(14'(ra) + 14'(rb) + 14'(rc)));
            step();
            if13.start = 1'b0;
            n = 0;
            while (!if13.done && n < 20) begin
                step();
                n++;
            end
            checkOutput("w13.latency", n, 13);
            e = q13.pop_front();
            checkOutput("w13.sum", if13.sum, e[12:0]);
            checkOutput("w13.cout", if13.cout, e[13]);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
